// File: rtl/ccd_adc_emu.sv
// ccd_adc_emu: emulates the serial output of the CCD video ADC. It answers
// ccd_timing on the adc_cs / adc_sclk / adc_sdo link and shifts out a
// pattern word (constant, ramp, LFSR or line index) in each frame.
// adc_cs and adc_sclk are oversampled on clk_80M through 2-flop synchronisers.
//
// Ports:
//   clk_80M     in   system clock, 80 MHz
//   rst         in   asynchronous active-high reset
//   en          in   emulator enable, sampled at the cs falling edge
//   mode        in   pattern select: 0 const, 1 ramp, 2 LFSR, 3 line index
//   const_val   in   word returned in mode 0
//   adc_cs      in   frame select, active low, asynchronous
//   adc_sclk    in   serial clock, idle high, asynchronous
//   adc_sdo     out  serial data, MSB first, registered
//   busy        out  high while a frame is in progress
//   short_frame out  one-cycle pulse when a frame ends too early
//   frame_cnt   out  completed full frames, wraps
module ccd_adc_emu #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned LINE_LEN  = 7500,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk_80M,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] const_val,
  input  logic              adc_cs,
  input  logic              adc_sclk,
  output logic              adc_sdo,
  output logic              busy,
  output logic              short_frame,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned LIDX_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Synchroniser and edge-history flops
  logic cs_meta, cs_sync, cs_prev;
  logic sclk_meta, sclk_sync, sclk_prev;

  // State and pattern sources
  logic [0:0]        state_q, state_n;
  logic [DATA_W-1:0] sh_q, sh_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [DATA_W-1:0] ramp_q, ramp_n;
  logic [15:0]       lfsr_q, lfsr_n;
  logic [LIDX_W-1:0] lidx_q, lidx_n;

  // Next values of the registered outputs
  logic              sdo_n, busy_n, short_n;
  logic [15:0]       fcnt_n;

  logic              cs_fall_c, cs_rise_c, sclk_fall_c;
  logic [DATA_W-1:0] word_c;
  logic              lfsr_fb_c;

  // Two-flop synchronisers; idle level of both lines is high
  always_ff @(posedge clk_80M or posedge rst) begin
    if (rst) begin
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      sclk_meta <= 1'b1;
      sclk_sync <= 1'b1;
      sclk_prev <= 1'b1;
    end else begin
      cs_meta   <= adc_cs;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      sclk_meta <= adc_sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
    end
  end

  assign cs_fall_c   = cs_prev & ~cs_sync;
  assign cs_rise_c   = ~cs_prev & cs_sync;
  assign sclk_fall_c = sclk_prev & ~sclk_sync;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1
  assign lfsr_fb_c = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Pattern word selected at the cs falling edge
  always_comb begin
    word_c = const_val;
    case (mode)
      2'd0:    word_c = const_val;
      2'd1:    word_c = ramp_q;
      2'd2:    word_c = DATA_W'(lfsr_q);
      default: word_c = DATA_W'(lidx_q);
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_n = state_q;
    sh_n    = sh_q;
    cnt_n   = cnt_q;
    ramp_n  = ramp_q;
    lfsr_n  = lfsr_q;
    lidx_n  = lidx_q;
    fcnt_n  = frame_cnt;
    sdo_n   = adc_sdo;
    busy_n  = busy;
    short_n = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sdo_n  = 1'b0;
        busy_n = 1'b0;
        if (cs_fall_c && en) begin
          state_n = ST_SHIFT;
          sh_n    = word_c;
          cnt_n   = '0;
          sdo_n   = word_c[DATA_W-1];
          busy_n  = 1'b1;
        end
      end

      ST_SHIFT: begin
        busy_n = 1'b1;
        if (cs_rise_c) begin
          // cs rise has priority over a coincident sclk fall
          state_n = ST_IDLE;
          busy_n  = 1'b0;
          sdo_n   = 1'b0;
          // The last bit is sampled on a rising edge, so DATA_W-1 falls suffice
          if (cnt_q >= CNT_W'(DATA_W - 1)) begin
            fcnt_n = frame_cnt + 16'd1;
            ramp_n = ramp_q + DATA_W'(1);
            lfsr_n = {lfsr_q[14:0], lfsr_fb_c};
            lidx_n = (lidx_q == LIDX_W'(LINE_LEN - 1)) ? '0 : lidx_q + LIDX_W'(1);
          end else begin
            short_n = 1'b1;
          end
        end else if (sclk_fall_c && (cnt_q < CNT_W'(DATA_W))) begin
          sh_n  = {sh_q[DATA_W-2:0], 1'b0};
          cnt_n = cnt_q + CNT_W'(1);
          // After the last data bit the line is held low until cs rises
          sdo_n = (cnt_q == CNT_W'(DATA_W - 1)) ? 1'b0 : sh_q[DATA_W-2];
        end
      end

      default: begin
        state_n = ST_IDLE;
        sdo_n   = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_80M or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      ramp_q      <= '0;
      lfsr_q      <= LFSR_SEED;
      lidx_q      <= '0;
      adc_sdo     <= 1'b0;
      busy        <= 1'b0;
      short_frame <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state_q     <= state_n;
      sh_q        <= sh_n;
      cnt_q       <= cnt_n;
      ramp_q      <= ramp_n;
      lfsr_q      <= lfsr_n;
      lidx_q      <= lidx_n;
      adc_sdo     <= sdo_n;
      busy        <= busy_n;
      short_frame <= short_n;
      frame_cnt   <= fcnt_n;
    end
  end

endmodule

// File: tb/tb_ccd_adc_emu.sv
// Bench for ccd_adc_emu: drives ccd_timing-style frames, keeps a timed
// expectation queue derived from pattern-source rules, and checks every cycle.
module tb_ccd_adc_emu;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned LINE_LEN = 4;
  localparam int unsigned LAT      = 3;

  logic        clk_80M = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] const_val = 16'h0000;
  logic        adc_cs = 1'b1;
  logic        adc_sclk = 1'b1;
  logic        adc_sdo;
  logic        busy;
  logic        short_frame;
  logic [15:0] frame_cnt;

  ccd_adc_emu #(
    .DATA_W(DATA_W),
    .LINE_LEN(LINE_LEN),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk_80M(clk_80M),
    .rst(rst),
    .en(en),
    .mode(mode),
    .const_val(const_val),
    .adc_cs(adc_cs),
    .adc_sclk(adc_sclk),
    .adc_sdo(adc_sdo),
    .busy(busy),
    .short_frame(short_frame),
    .frame_cnt(frame_cnt)
  );

  always #6 clk_80M = ~clk_80M;

  int cyc = 0;
  always @(posedge clk_80M) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          t;
    logic        sdo;
    logic        bsy;
    logic        sf;
    logic [15:0] fc;
  } ev_t;
  ev_t evq[$];

  logic        e_sdo = 1'b0;
  logic        e_busy = 1'b0;
  logic        e_sf = 1'b0;
  logic [15:0] e_fc = 16'h0000;

  // Pattern-source model
  logic [15:0] m_ramp;
  logic [15:0] m_lfsr;
  int          m_lidx;
  logic [15:0] m_fc;

  logic [15:0] rx;
  logic [15:0] exp_lfsr[3];
  logic [15:0] exp_line[6];

  task automatic push(input int t, input logic sdo, input logic bsy, input logic sf);
    ev_t ev;
    ev.t = t; ev.sdo = sdo; ev.bsy = bsy; ev.sf = sf; ev.fc = m_fc;
    evq.push_back(ev);
  endtask

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_80M);
      #1;
    end
  endtask

  // Per-cycle comparison of all outputs against the timed expectations
  task automatic monitor();
    ev_t ev;
    forever begin
      @(negedge clk_80M);
      if (cyc > 0) begin
        while (evq.size() > 0 && evq[0].t <= cyc) begin
          ev = evq.pop_front();
          e_sdo = ev.sdo; e_busy = ev.bsy; e_sf = ev.sf; e_fc = ev.fc;
        end
        n_cmp++;
        if ({adc_sdo, busy, short_frame, frame_cnt} !== {e_sdo, e_busy, e_sf, e_fc}) begin
          n_bad++;
          $display("FAIL cycle %0d outputs: got sdo=%b busy=%b short=%b cnt=%h required sdo=%b busy=%b short=%b cnt=%h",
                   cyc, adc_sdo, busy, short_frame, frame_cnt, e_sdo, e_busy, e_sf, e_fc);
        end
      end
    end
  endtask

  function automatic logic [15:0] model_word(input logic [1:0] md, input logic [15:0] cv);
    case (md)
      2'd0:    return cv;
      2'd1:    return m_ramp;
      2'd2:    return m_lfsr;
      default: return 16'(m_lidx);
    endcase
  endfunction

  task automatic model_reset();
    m_ramp = 16'h0000;
    m_lfsr = 16'hACE1;
    m_lidx = 0;
    m_fc   = 16'h0000;
  endtask

  task automatic model_advance();
    m_ramp = m_ramp + 16'd1;
    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    m_lidx = (m_lidx + 1) % LINE_LEN;
    m_fc   = m_fc + 16'd1;
  endtask

  // One frame: cs low, MSB read before the first fall, then n_falls sclk
  // periods at 10 MHz with a read on each rising edge.
  task automatic frame(input int n_falls, input logic drop_en, input logic abort,
                       output logic [15:0] rd);
    logic [15:0] w;
    logic        act;
    logic        b;
    act = en;
    w   = model_word(mode, const_val);
    rd  = 16'h0000;
    adc_cs = 1'b0;
    if (act) push(cyc + LAT, w[15], 1'b1, 1'b0);
    tick(4);
    rd[15] = adc_sdo;
    if (drop_en) en = 1'b0;
    for (int k = 1; k <= n_falls; k++) begin
      adc_sclk = 1'b0;
      b = 1'b0;
      if (k < 16) b = w[4'(15 - k)];
      if (act) push(cyc + LAT, b, 1'b1, 1'b0);
      tick(4);
      adc_sclk = 1'b1;
      if (k < 16) rd[4'(15 - k)] = adc_sdo;
      tick(4);
    end
    if (!abort) begin
      adc_cs = 1'b1;
      if (act) begin
        if (n_falls >= 15) begin
          model_advance();
          push(cyc + LAT, 1'b0, 1'b0, 1'b0);
        end else begin
          push(cyc + LAT, 1'b0, 1'b0, 1'b1);
          push(cyc + LAT + 1, 1'b0, 1'b0, 1'b0);
        end
      end
      tick(6);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    adc_cs = 1'b1;
    adc_sclk = 1'b1;
    evq.delete();
    model_reset();
    push(cyc, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_sdo", 16'(adc_sdo), 16'h0000);
    check("rst_busy", 16'(busy), 16'h0000);
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    exp_lfsr = '{16'hACE1, 16'h59C3, 16'hB387};
    exp_line = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
    model_reset();
    fork
      monitor();
    join_none
    tick(3);
    rst = 1'b0;
    tick(2);
    check("reset_frame_cnt", frame_cnt, 16'h0000);
    check("reset_short", 16'(short_frame), 16'h0000);

    // Constant word
    en = 1'b1; mode = 2'd0; const_val = 16'hA55A;
    frame(16, 1'b0, 1'b0, rx);
    check("const_word", rx, 16'hA55A);
    check("const_cnt", frame_cnt, 16'd1);

    // Ramp
    do_reset();
    mode = 2'd1;
    for (int i = 0; i < 5; i++) begin
      frame(16, 1'b0, 1'b0, rx);
      check($sformatf("ramp_word%0d", i), rx, 16'(i));
    end
    check("ramp_cnt", frame_cnt, 16'd5);

    // LFSR
    do_reset();
    mode = 2'd2;
    for (int i = 0; i < 3; i++) begin
      frame(16, 1'b0, 1'b0, rx);
      check($sformatf("lfsr_word%0d", i), rx, exp_lfsr[i]);
    end

    // Short frames and the DATA_W-1 boundary
    do_reset();
    mode = 2'd1;
    frame(8, 1'b0, 1'b0, rx);
    check("short8_cnt", frame_cnt, 16'd0);
    frame(16, 1'b0, 1'b0, rx);
    check("after_short_word", rx, 16'h0000);
    check("after_short_cnt", frame_cnt, 16'd1);
    frame(14, 1'b0, 1'b0, rx);
    check("short14_cnt", frame_cnt, 16'd1);
    frame(15, 1'b0, 1'b0, rx);
    check("fall15_word", rx, 16'h0001);
    check("fall15_cnt", frame_cnt, 16'd2);
    frame(16, 1'b0, 1'b0, rx);
    check("after15_word", rx, 16'h0002);

    // Line index with wrap
    do_reset();
    mode = 2'd3;
    for (int i = 0; i < 6; i++) begin
      frame(16, 1'b0, 1'b0, rx);
      check($sformatf("line_word%0d", i), rx, exp_line[i]);
    end

    // Reset in the middle of a frame
    mode = 2'd1;
    frame(5, 1'b0, 1'b1, rx);
    check("midframe_busy", 16'(busy), 16'h0001);
    do_reset();
    check("post_rst_cnt", frame_cnt, 16'h0000);
    frame(16, 1'b0, 1'b0, rx);
    check("post_rst_word", rx, 16'h0000);

    // Disabled frame, then enable dropped mid-frame
    en = 1'b0;
    frame(16, 1'b0, 1'b0, rx);
    check("dis_word", rx, 16'h0000);
    check("dis_cnt", frame_cnt, 16'd1);
    en = 1'b1;
    frame(16, 1'b1, 1'b0, rx);
    check("endrop_word", rx, 16'h0001);
    check("endrop_cnt", frame_cnt, 16'd2);
    en = 1'b1;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ccd_adc_emu.md
Name: ccd_adc_emu

Overview:
- Synthesisable emulator of the CCD video ADC's serial output: the responder end of the adc_cs / adc_sclk / adc_sdo link that ccd_timing drives as initiator.
- Replaces the real ADC on the board (mux-selected) and in simulation, so ccd_timing, pixel capture and the downstream pipeline can be verified against known pixel values.
- Runs entirely in the clk_80M domain and oversamples the serial control lines.

Parameters:
- DATA_W, 16, bits per conversion word shifted out MSB first.
- LINE_LEN, 7500, conversions per CCD line for pattern mode 3 (index wraps after LINE_LEN frames).
- LFSR_SEED, 16'hACE1, LFSR reset value, must be non-zero.

Ports:
- clk_80M  in  1  system clock, 80 MHz.
- rst  in  1  asynchronous active-high reset.
- en  in  1  emulator enable; when low, frames are ignored.
- mode  in  2  pattern select: 0 const, 1 ramp, 2 LFSR, 3 line index.
- const_val  in  DATA_W  word returned in mode 0.
- adc_cs  in  1  frame select from ccd_timing, active low, asynchronous to clk_80M sampling.
- adc_sclk  in  1  serial clock from ccd_timing, idle high.
- adc_sdo  out  1  serial data to ccd_timing.
- busy  out  1  high while a frame is in progress.
- short_frame  out  1  one-cycle pulse when a frame ends with fewer than DATA_W bits clocked.
- frame_cnt  out  16  completed full frames, wraps 0xFFFF to 0.

Behaviour:
- Reset values: adc_sdo 0, busy 0, short_frame 0, frame_cnt 0, ramp 0, LFSR LFSR_SEED, line index 0, FSM IDLE.
- Input sync: adc_cs and adc_sclk each pass through a 2-flop synchroniser. Edges are detected on the synchronised copies. The synchroniser flops reset to 1.
- Timing limit: sclk high and low phases must each be at least 4 clk_80M cycles (sclk ≤ 10 MHz). Behaviour above this limit is undefined.
- FSM IDLE:
  - adc_sdo = 0.
  - On cs falling edge with en = 1: latch mode/const_val, load the shift register with the pattern word, set bit_cnt = 0, go to SHIFT.
  - busy rises on the cycle after the edge is detected.
  - adc_sdo shows the word MSB 3 clk_80M cycles after the cs pin falls (2 sync + 1 register).
- FSM SHIFT:
  - On each sclk falling edge: shift left, bit_cnt++. adc_sdo shows the next bit 3 cycles after the pin edge.
  - ccd_timing samples on the sclk rising edge.
  - After DATA_W falling edges, adc_sdo = 0 and stays 0 until cs rises.
- Frame end (cs rising edge in SHIFT):
  - If bit_cnt ≥ DATA_W-1: frame_cnt++ and advance the pattern source.
  - Otherwise: pulse short_frame for 1 cycle; frame_cnt and the pattern source do not change.
  - In both cases go to IDLE with busy = 0 and adc_sdo = 0.
  - Rationale for DATA_W-1: the last bit is sampled on a rising edge and needs no further falling edge.
- Pattern sources (all advance only on a completed full frame):
  - ramp: +1 per frame, wraps to 0.
  - LFSR: Fibonacci x^16+x^14+x^13+x^11+1, shift left, feedback into the LSB.
  - line index: +1 per frame; resets to 0 after value LINE_LEN-1.
  - The word is sampled at cs fall, so changing mode mid-frame takes effect at the next frame.
- sclk edges in IDLE: ignored.
- cs falls while en = 0: the frame is ignored; the block stays in IDLE until the next cs fall with en = 1.
- en falls mid-frame: the current frame completes normally.
- cs rising edge and sclk falling edge in the same cycle: the cs rising edge wins; the sclk edge is discarded.
- Reset asserted mid-frame: all state returns to reset values immediately. The frame in progress is lost and produces no short_frame pulse.

Test Plan:
- mode 0, const_val 16'hA55A, one 16-bit frame at 10 MHz sclk → receiver reads 0xA55A, frame_cnt = 1, short_frame never asserts.
- mode 1, 5 consecutive full frames → words 0x0000, 0x0001, 0x0002, 0x0003, 0x0004; frame_cnt = 5.
- mode 2, 3 frames → first word 0xACE1, then the next two LFSR states (computed by the bench model); adc_sdo bit timing is 3 cycles after each sclk fall.
- mode 1, cs raised after 8 sclk falls → short_frame pulse of exactly 1 cycle, frame_cnt unchanged, next full frame returns the same word (0x0000).
- mode 3 with LINE_LEN overridden to 4, 6 frames → 0, 1, 2, 3, 0, 1.
- Assert rst mid-frame after 5 bits → adc_sdo = 0 and busy = 0 within the reset cycle; en = 0 during a cs frame → adc_sdo stays 0 and frame_cnt is unchanged.
